// File: rtl/mfi_retire_order_buffer.sv
`default_nettype none
// ============================================================================
// Module   : mfi_retire_order_buffer
// Brief    : Reorders dual-lane retire records into one in-order MFI stream.
// Revision : 1.0
// ============================================================================
module mfi_retire_order_buffer #(
  parameter int XLEN   = 32,
  parameter int DEPTH  = 8,
  parameter int ORDERW = 64
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [1:0]                in_valid,
  input  logic [2*ORDERW-1:0]       in_order,
  input  logic [2*32-1:0]           in_insn,
  input  logic [2*XLEN-1:0]         in_pc_rdata,
  input  logic [2*XLEN-1:0]         in_pc_wdata,
  output logic                      in_ready,
  output logic                      mfi_valid,
  output logic [ORDERW-1:0]         mfi_order,
  output logic [31:0]               mfi_insn,
  output logic [XLEN-1:0]           mfi_pc_rdata,
  output logic [XLEN-1:0]           mfi_pc_wdata,
  output logic [$clog2(DEPTH):0]    count,
  output logic                      err
);

  localparam int                c_IDXW      = $clog2(DEPTH);
  localparam logic [ORDERW-1:0] c_DEPTH_O   = ORDERW'(DEPTH);
  localparam logic [c_IDXW:0]   c_READY_MAX = (c_IDXW + 1)'(DEPTH - 2);
  localparam logic [ORDERW-1:0] c_ONE_O     = {{(ORDERW - 1){1'b0}}, 1'b1};

  logic [ORDERW-1:0] r_head;
  logic [DEPTH-1:0]  r_slot_valid;
  logic [ORDERW-1:0] r_slot_order [DEPTH];
  logic [31:0]       r_slot_insn  [DEPTH];
  logic [XLEN-1:0]   r_slot_pcr   [DEPTH];
  logic [XLEN-1:0]   r_slot_pcw   [DEPTH];
  logic [c_IDXW:0]   r_count;
  logic              r_err;
  logic              r_mfi_valid;
  logic [ORDERW-1:0] r_mfi_order;
  logic [31:0]       r_mfi_insn;
  logic [XLEN-1:0]   r_mfi_pcr;
  logic [XLEN-1:0]   r_mfi_pcw;

  logic              w_ready;
  logic [1:0]        w_accept;
  logic [1:0]        w_reject;
  logic [c_IDXW-1:0] w_idx        [2];
  logic [ORDERW-1:0] w_lane_order [2];
  logic [31:0]       w_lane_insn  [2];
  logic [XLEN-1:0]   w_lane_pcr   [2];
  logic [XLEN-1:0]   w_lane_pcw   [2];
  logic [c_IDXW-1:0] w_head_idx;
  logic              w_drain;
  logic [DEPTH-1:0]  w_slot_valid_nxt;
  logic [c_IDXW:0]   w_count_nxt;

  assign w_ready    = (r_count <= c_READY_MAX);
  assign w_head_idx = r_head[c_IDXW-1:0];
  assign w_drain    = r_slot_valid[w_head_idx];

  // Window and occupancy use pre-edge head/slot state only, so an order at
  // head+DEPTH stays out of window even when slot[head] drains this edge.
  for (genvar k = 0; k < 2; k++) begin : g_lane
    logic [ORDERW-1:0] w_dist;
    logic              w_in_window;
    logic              w_slot_free;
    logic              w_dup;
    logic              w_offer;

    assign w_lane_order[k] = in_order[k*ORDERW +: ORDERW];
    assign w_lane_insn[k]  = in_insn[k*32 +: 32];
    assign w_lane_pcr[k]   = in_pc_rdata[k*XLEN +: XLEN];
    assign w_lane_pcw[k]   = in_pc_wdata[k*XLEN +: XLEN];
    assign w_idx[k]        = w_lane_order[k][c_IDXW-1:0];

    assign w_dist      = w_lane_order[k] - r_head;
    assign w_in_window = (w_dist < c_DEPTH_O);
    assign w_slot_free = !r_slot_valid[w_idx[k]];

    if (k == 1) begin : g_dup
      assign w_dup = in_valid[0] && (w_lane_order[1] == w_lane_order[0]);
    end else begin : g_no_dup
      assign w_dup = 1'b0;
    end

    assign w_offer     = in_valid[k] && w_ready;
    assign w_accept[k] = w_offer && w_in_window && w_slot_free && !w_dup;
    assign w_reject[k] = w_offer && !w_accept[k];
  end

  always_comb begin
    w_slot_valid_nxt = r_slot_valid;
    if (w_drain) begin
      w_slot_valid_nxt[w_head_idx] = 1'b0;
    end
    for (int k = 0; k < 2; k++) begin
      if (w_accept[k]) begin
        w_slot_valid_nxt[w_idx[k]] = 1'b1;
      end
    end
  end

  assign w_count_nxt = r_count
                     + {{c_IDXW{1'b0}}, w_accept[0]}
                     + {{c_IDXW{1'b0}}, w_accept[1]}
                     - {{c_IDXW{1'b0}}, w_drain};

  always_ff @(posedge clock) begin
    if (reset) begin
      r_head       <= '0;
      r_slot_valid <= '0;
      r_count      <= '0;
      r_err        <= 1'b0;
      r_mfi_valid  <= 1'b0;
      r_mfi_order  <= '0;
      r_mfi_insn   <= '0;
      r_mfi_pcr    <= '0;
      r_mfi_pcw    <= '0;
    end else begin
      r_slot_valid <= w_slot_valid_nxt;
      r_count      <= w_count_nxt;
      r_mfi_valid  <= w_drain;
      if (|w_reject) begin
        r_err <= 1'b1;
      end
      if (w_drain) begin
        r_head      <= r_head + c_ONE_O;
        r_mfi_order <= r_slot_order[w_head_idx];
        r_mfi_insn  <= r_slot_insn[w_head_idx];
        r_mfi_pcr   <= r_slot_pcr[w_head_idx];
        r_mfi_pcw   <= r_slot_pcw[w_head_idx];
      end
    end
  end

  // Payload needs no reset: a slot is only read while its valid bit is set.
  always_ff @(posedge clock) begin
    for (int k = 0; k < 2; k++) begin
      if (w_accept[k]) begin
        r_slot_order[w_idx[k]] <= w_lane_order[k];
        r_slot_insn[w_idx[k]]  <= w_lane_insn[k];
        r_slot_pcr[w_idx[k]]   <= w_lane_pcr[k];
        r_slot_pcw[w_idx[k]]   <= w_lane_pcw[k];
      end
    end
  end

  assign in_ready     = w_ready;
  assign mfi_valid    = r_mfi_valid;
  assign mfi_order    = r_mfi_order;
  assign mfi_insn     = r_mfi_insn;
  assign mfi_pc_rdata = r_mfi_pcr;
  assign mfi_pc_wdata = r_mfi_pcw;
  assign count        = r_count;
  assign err          = r_err;

endmodule
`default_nettype wire

// File: tb/tb_mfi_retire_order_buffer.sv
`default_nettype none
// ============================================================================
// Module   : tb_mfi_retire_order_buffer
// Brief    : Directed self-checking bench for mfi_retire_order_buffer.
// Revision : 1.0
// ============================================================================
module tb_mfi_retire_order_buffer;

  localparam int XLEN   = 32;
  localparam int DEPTH  = 8;
  localparam int ORDERW = 64;
  localparam int WORDW  = 4;
  localparam int WXLEN  = 16;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  logic [1:0]          in_valid    = '0;
  logic [2*ORDERW-1:0] in_order    = '0;
  logic [63:0]         in_insn     = '0;
  logic [2*XLEN-1:0]   in_pc_rdata = '0;
  logic [2*XLEN-1:0]   in_pc_wdata = '0;
  logic                in_ready;
  logic                mfi_valid;
  logic [ORDERW-1:0]   mfi_order;
  logic [31:0]         mfi_insn;
  logic [XLEN-1:0]     mfi_pc_rdata;
  logic [XLEN-1:0]     mfi_pc_wdata;
  logic [3:0]          count;
  logic                err;

  logic [1:0]          w_in_valid    = '0;
  logic [2*WORDW-1:0]  w_in_order    = '0;
  logic [63:0]         w_in_insn     = '0;
  logic [2*WXLEN-1:0]  w_in_pc_rdata = '0;
  logic [2*WXLEN-1:0]  w_in_pc_wdata = '0;
  logic                w_in_ready;
  logic                w_mfi_valid;
  logic [WORDW-1:0]    w_mfi_order;
  logic [31:0]         w_mfi_insn;
  logic [WXLEN-1:0]    w_mfi_pc_rdata;
  logic [WXLEN-1:0]    w_mfi_pc_wdata;
  logic [3:0]          w_count;
  logic                w_err;

  mfi_retire_order_buffer #(.XLEN(XLEN), .DEPTH(DEPTH), .ORDERW(ORDERW)) u_dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_order(in_order),
    .in_insn(in_insn), .in_pc_rdata(in_pc_rdata), .in_pc_wdata(in_pc_wdata),
    .in_ready(in_ready), .mfi_valid(mfi_valid), .mfi_order(mfi_order),
    .mfi_insn(mfi_insn), .mfi_pc_rdata(mfi_pc_rdata), .mfi_pc_wdata(mfi_pc_wdata),
    .count(count), .err(err)
  );

  mfi_retire_order_buffer #(.XLEN(WXLEN), .DEPTH(DEPTH), .ORDERW(WORDW)) u_wrap (
    .clock(clock), .reset(reset), .in_valid(w_in_valid), .in_order(w_in_order),
    .in_insn(w_in_insn), .in_pc_rdata(w_in_pc_rdata), .in_pc_wdata(w_in_pc_wdata),
    .in_ready(w_in_ready), .mfi_valid(w_mfi_valid), .mfi_order(w_mfi_order),
    .mfi_insn(w_mfi_insn), .mfi_pc_rdata(w_mfi_pc_rdata), .mfi_pc_wdata(w_mfi_pc_wdata),
    .count(w_count), .err(w_err)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  logic [63:0] q_ord [$];
  logic [31:0] q_pcr [$];
  logic [3:0]  wq    [$];

  always @(negedge clock) begin
    if (!reset && mfi_valid) begin
      q_ord.push_back(mfi_order);
      q_pcr.push_back(mfi_pc_rdata);
    end
    if (!reset && w_mfi_valid) begin
      wq.push_back(w_mfi_order);
    end
  end

  function automatic logic [31:0] pcr_of(input logic [63:0] o);
    return 32'h100 + o[31:0] * 32'd4;
  endfunction

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    in_valid   = 2'b00;
    w_in_valid = 2'b00;
  endtask

  task automatic set_lane(input int k, input logic [63:0] o);
    in_order[k*ORDERW +: ORDERW] = o;
    in_insn[k*32 +: 32]          = 32'hA000_0000 | {16'h0, o[15:0]};
    in_pc_rdata[k*XLEN +: XLEN]  = pcr_of(o);
    in_pc_wdata[k*XLEN +: XLEN]  = pcr_of(o) + 32'd4;
    in_valid[k]                  = 1'b1;
  endtask

  task automatic do_reset();
    idle();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    q_ord.delete();
    q_pcr.delete();
    wq.delete();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    set_lane(0, 64'd0);
    set_lane(1, 64'd1);
    step();
    step();
    reset = 1'b0;
    idle();
    n_cmp++; if (count !== 4'd0) begin n_fail++; $display("FAIL reset_count: got %0d want 0", count); end
    n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b want 1", in_ready); end
    n_cmp++; if (mfi_valid !== 1'b0) begin n_fail++; $display("FAIL reset_mfi_valid: got %b want 0", mfi_valid); end
    n_cmp++; if (err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b want 0", err); end
    n_cmp++; if (mfi_order !== 64'd0) begin n_fail++; $display("FAIL reset_mfi_order: got %0d want 0", mfi_order); end
    n_cmp++; if (mfi_pc_rdata !== 32'd0) begin n_fail++; $display("FAIL reset_mfi_pc: got %h want 0", mfi_pc_rdata); end
    step();
    // Entries presented during reset must not have been captured.
    n_cmp++; if (mfi_valid !== 1'b0 || count !== 4'd0) begin n_fail++; $display("FAIL reset_inputs_ignored: got valid=%b count=%0d want 0/0", mfi_valid, count); end
  endtask

  task automatic test_in_order();
    do_reset();
    set_lane(0, 64'd0); step();
    n_cmp++; if (mfi_valid !== 1'b0 || count !== 4'd1) begin n_fail++; $display("FAIL inord_e0: got valid=%b count=%0d want 0/1", mfi_valid, count); end
    set_lane(0, 64'd1); step();
    n_cmp++; if (mfi_valid !== 1'b1 || mfi_order !== 64'd0 || count !== 4'd1) begin n_fail++; $display("FAIL inord_e1: got valid=%b order=%0d count=%0d want 1/0/1", mfi_valid, mfi_order, count); end
    set_lane(0, 64'd2); step();
    n_cmp++; if (mfi_valid !== 1'b1 || mfi_order !== 64'd1) begin n_fail++; $display("FAIL inord_e2: got valid=%b order=%0d want 1/1", mfi_valid, mfi_order); end
    idle(); step();
    n_cmp++; if (mfi_valid !== 1'b1 || mfi_order !== 64'd2 || count !== 4'd0) begin n_fail++; $display("FAIL inord_e3: got valid=%b order=%0d count=%0d want 1/2/0", mfi_valid, mfi_order, count); end
    step();
    n_cmp++; if (mfi_valid !== 1'b0 || err !== 1'b0) begin n_fail++; $display("FAIL inord_end: got valid=%b err=%b want 0/0", mfi_valid, err); end
  endtask

  task automatic test_out_of_order();
    do_reset();
    set_lane(0, 64'd1); set_lane(1, 64'd2); step();
    n_cmp++; if (count !== 4'd2 || mfi_valid !== 1'b0) begin n_fail++; $display("FAIL ooo_c0: got count=%0d valid=%b want 2/0", count, mfi_valid); end
    idle(); set_lane(0, 64'd0); step();
    n_cmp++; if (count !== 4'd3 || mfi_valid !== 1'b0) begin n_fail++; $display("FAIL ooo_c1: got count=%0d valid=%b want 3/0", count, mfi_valid); end
    idle(); step();
    n_cmp++; if (mfi_valid !== 1'b1 || mfi_order !== 64'd0) begin n_fail++; $display("FAIL ooo_rec0: got valid=%b order=%0d want 1/0", mfi_valid, mfi_order); end
    n_cmp++; if (mfi_pc_rdata !== 32'h100 || mfi_pc_wdata !== 32'h104) begin n_fail++; $display("FAIL ooo_rec0_pc: got %h/%h want 100/104", mfi_pc_rdata, mfi_pc_wdata); end
    n_cmp++; if (mfi_insn !== 32'hA000_0000) begin n_fail++; $display("FAIL ooo_rec0_insn: got %h want a0000000", mfi_insn); end
    step();
    n_cmp++; if (mfi_valid !== 1'b1 || mfi_order !== 64'd1) begin n_fail++; $display("FAIL ooo_rec1: got valid=%b order=%0d want 1/1", mfi_valid, mfi_order); end
    step();
    n_cmp++; if (mfi_valid !== 1'b1 || mfi_order !== 64'd2 || count !== 4'd0) begin n_fail++; $display("FAIL ooo_rec2: got valid=%b order=%0d count=%0d want 1/2/0", mfi_valid, mfi_order, count); end
    n_cmp++; if (err !== 1'b0) begin n_fail++; $display("FAIL ooo_err: got %b want 0", err); end
  endtask

  task automatic test_backpressure();
    do_reset();
    set_lane(0, 64'd1); set_lane(1, 64'd2); step();
    set_lane(0, 64'd3); set_lane(1, 64'd4); step();
    set_lane(0, 64'd5); set_lane(1, 64'd6); step();
    // Six occupied still satisfies count <= DEPTH-2.
    n_cmp++; if (count !== 4'd6 || in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_fill: got count=%0d ready=%b want 6/1", count, in_ready); end
    idle(); set_lane(0, 64'd0); step();
    n_cmp++; if (count !== 4'd7 || in_ready !== 1'b0 || mfi_valid !== 1'b0) begin n_fail++; $display("FAIL bp_full: got count=%0d ready=%b valid=%b want 7/0/0", count, in_ready, mfi_valid); end
    idle(); step();
    n_cmp++; if (count !== 4'd6 || in_ready !== 1'b1 || mfi_order !== 64'd0) begin n_fail++; $display("FAIL bp_drain0: got count=%0d ready=%b order=%0d want 6/1/0", count, in_ready, mfi_order); end
    for (int i = 0; i < 8; i++) step();
    n_cmp++; if (q_ord.size() != 7) begin n_fail++; $display("FAIL bp_records: got %0d want 7", q_ord.size()); end
    if (q_ord.size() == 7) begin
      for (int i = 0; i < 7; i++) begin
        n_cmp++; if (q_ord[i] !== 64'(i) || q_pcr[i] !== pcr_of(64'(i))) begin n_fail++; $display("FAIL bp_rec%0d: got order=%0d pc=%h want %0d/%h", i, q_ord[i], q_pcr[i], i, pcr_of(64'(i))); end
      end
    end
    n_cmp++; if (count !== 4'd0 || in_ready !== 1'b1 || err !== 1'b0) begin n_fail++; $display("FAIL bp_end: got count=%0d ready=%b err=%b want 0/1/0", count, in_ready, err); end
  endtask

  task automatic test_violations();
    // Duplicate order on both lanes: lane 1 dropped.
    do_reset();
    set_lane(0, 64'd3); set_lane(1, 64'd3); step();
    n_cmp++; if (err !== 1'b1 || count !== 4'd1) begin n_fail++; $display("FAIL dup_drop: got err=%b count=%0d want 1/1", err, count); end
    set_lane(0, 64'd0); set_lane(1, 64'd1); step();
    idle(); set_lane(0, 64'd2); step();
    idle();
    for (int i = 0; i < 6; i++) step();
    n_cmp++; if (q_ord.size() != 4 || count !== 4'd0) begin n_fail++; $display("FAIL dup_records: got n=%0d count=%0d want 4/0", q_ord.size(), count); end
    if (q_ord.size() == 4) begin
      n_cmp++; if (q_ord[3] !== 64'd3 || q_ord[2] !== 64'd2) begin n_fail++; $display("FAIL dup_order: got %0d,%0d want 2,3", q_ord[2], q_ord[3]); end
    end

    // head+DEPTH rejected even though slot[head] drains the same edge.
    do_reset();
    set_lane(0, 64'd0); step();
    n_cmp++; if (err !== 1'b0 || count !== 4'd1) begin n_fail++; $display("FAIL win_pre: got err=%b count=%0d want 0/1", err, count); end
    set_lane(0, 64'd8); set_lane(1, 64'd1); step();
    n_cmp++; if (err !== 1'b1 || count !== 4'd1 || mfi_order !== 64'd0) begin n_fail++; $display("FAIL win_reject: got err=%b count=%0d order=%0d want 1/1/0", err, count, mfi_order); end
    idle(); step(); step();
    n_cmp++; if (q_ord.size() != 2 || count !== 4'd0) begin n_fail++; $display("FAIL win_records: got n=%0d count=%0d want 2/0", q_ord.size(), count); end

    // Re-send of a still-buffered order.
    do_reset();
    set_lane(0, 64'd2); step();
    n_cmp++; if (err !== 1'b0 || count !== 4'd1) begin n_fail++; $display("FAIL resend_pre: got err=%b count=%0d want 0/1", err, count); end
    set_lane(0, 64'd2); set_lane(1, 64'd3); step();
    n_cmp++; if (err !== 1'b1 || count !== 4'd2) begin n_fail++; $display("FAIL resend_drop: got err=%b count=%0d want 1/2", err, count); end
    set_lane(0, 64'd0); set_lane(1, 64'd1); step();
    idle();
    for (int i = 0; i < 6; i++) step();
    n_cmp++; if (q_ord.size() != 4 || count !== 4'd0) begin n_fail++; $display("FAIL resend_records: got n=%0d count=%0d want 4/0", q_ord.size(), count); end
    if (q_ord.size() == 4) begin
      n_cmp++; if (q_ord[2] !== 64'd2 || q_pcr[2] !== pcr_of(64'd2)) begin n_fail++; $display("FAIL resend_rec2: got %0d/%h want 2/%h", q_ord[2], q_pcr[2], pcr_of(64'd2)); end
    end
  endtask

  task automatic test_wrap();
    logic [3:0] o;
    do_reset();
    for (int i = 0; i < 20; i++) begin
      o = 4'(i);
      w_in_order[3:0]  = o;
      w_in_insn[31:0]  = {28'h0, o};
      w_in_pc_rdata[15:0] = {12'h0, o};
      w_in_pc_wdata[15:0] = {12'h0, o} + 16'd4;
      w_in_valid = 2'b01;
      step();
    end
    idle();
    for (int i = 0; i < 4; i++) step();
    n_cmp++; if (wq.size() != 20) begin n_fail++; $display("FAIL wrap_records: got %0d want 20", wq.size()); end
    if (wq.size() == 20) begin
      for (int i = 14; i < 20; i++) begin
        n_cmp++; if (wq[i] !== 4'(i)) begin n_fail++; $display("FAIL wrap_rec%0d: got %0d want %0d", i, wq[i], i % 16); end
      end
    end
    n_cmp++; if (w_err !== 1'b0 || w_count !== 4'd0) begin n_fail++; $display("FAIL wrap_end: got err=%b count=%0d want 0/0", w_err, w_count); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    set_lane(0, 64'd1); set_lane(1, 64'd2); step();
    set_lane(0, 64'd3); set_lane(1, 64'd4); step();
    n_cmp++; if (count !== 4'd4) begin n_fail++; $display("FAIL rmid_fill: got %0d want 4", count); end
    idle(); set_lane(0, 64'd0);
    reset = 1'b1; step();
    n_cmp++; if (count !== 4'd0 || mfi_valid !== 1'b0 || in_ready !== 1'b1) begin n_fail++; $display("FAIL rmid_reset: got count=%0d valid=%b ready=%b want 0/0/1", count, mfi_valid, in_ready); end
    reset = 1'b0; idle(); step();
    n_cmp++; if (count !== 4'd0 || mfi_valid !== 1'b0) begin n_fail++; $display("FAIL rmid_ignored: got count=%0d valid=%b want 0/0", count, mfi_valid); end
    set_lane(0, 64'd0); step();
    idle(); step();
    n_cmp++; if (mfi_valid !== 1'b1 || mfi_order !== 64'd0) begin n_fail++; $display("FAIL rmid_rec0: got valid=%b order=%0d want 1/0", mfi_valid, mfi_order); end
    step();
    n_cmp++; if (mfi_valid !== 1'b0 || count !== 4'd0 || err !== 1'b0) begin n_fail++; $display("FAIL rmid_end: got valid=%b count=%0d err=%b want 0/0/0", mfi_valid, count, err); end
  endtask

  initial begin
    test_reset();
    test_in_order();
    test_out_of_order();
    test_backpressure();
    test_violations();
    test_wrap();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
